// File: rtl/reg_dst_scoreboard_if.sv
// ---------------------------------------------------------------------------
// reg_dst_scoreboard_if
//   Bundles the decode-stage signals exchanged between the ID stage and the
//   destination-register scoreboard.
//
//   master : the decoder side; drives the decoded instruction fields, receives
//            the mux select, stall/issue and the registered EX destination.
//   slave  : the scoreboard side (reg_dst_scoreboard).
//
//   Handshake: id_valid is the request, !stall is the ready; an instruction is
//   accepted (moves ID->EX) exactly on cycles with issue=1, i.e.
//   id_valid && !stall && !flush. While stall=1 the decoder must hold its
//   instruction unchanged.
// ---------------------------------------------------------------------------
interface reg_dst_scoreboard_if #(
  parameter int LAT_W = 3,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic [4:0]       id_rd;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic             id_writes_reg;
  logic             id_reg_dst;
  logic [LAT_W-1:0] id_latency;
  logic             flush;
  logic             dst_sel;
  logic             stall;
  logic             issue;
  logic [4:0]       ex_dst;
  logic             ex_dst_valid;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_writes_reg, id_reg_dst, id_latency, flush,
    input  dst_sel, stall, issue, ex_dst, ex_dst_valid, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rd, id_uses_rs, id_uses_rt,
           id_writes_reg, id_reg_dst, id_latency, flush,
    output dst_sel, stall, issue, ex_dst, ex_dst_valid, stall_cycles
  );
endinterface

// File: rtl/reg_dst_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_dst_scoreboard
//   Decode-stage scoreboard / interlock for the MIPS pipeline. Selects the
//   destination register (rt or rd), keeps a per-register countdown of cycles
//   until a pending result is forwardable, stalls decode while any used
//   source is pending, and registers the issued destination for EX.
//
//   Ports:
//     clk      : pipeline clock, rising edge
//     reset_n  : synchronous active-low reset
//     sb       : reg_dst_scoreboard_if.slave (decode fields in; dst_sel,
//                stall, issue, ex_dst, ex_dst_valid, stall_cycles out)
// ---------------------------------------------------------------------------
module reg_dst_scoreboard #(
  parameter int LAT_W = 3,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  reg_dst_scoreboard_if.slave sb
);

  // Entry 0 is kept permanently zero so r0 never creates a hazard.
  logic [LAT_W-1:0] pend_q [32];
  logic [LAT_W-1:0] pend_d [32];
  logic [4:0]       ex_dst_q, ex_dst_d;
  logic             ex_dst_valid_q, ex_dst_valid_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [4:0] dst;
  logic       haz;
  logic       stall;
  logic       issue;

  assign dst = sb.id_reg_dst ? sb.id_rd : sb.id_rt;

  // Hazard looks only at the current (pre-update) countdowns, so an
  // instruction that reads its own destination never stalls on itself.
  assign haz   = sb.id_valid &&
                 ((sb.id_uses_rs && (pend_q[sb.id_rs] != '0)) ||
                  (sb.id_uses_rt && (pend_q[sb.id_rt] != '0)));
  assign stall = haz && !sb.flush;
  assign issue = sb.id_valid && !stall && !sb.flush;

  always_comb begin
    pend_d[0] = '0;
    for (int r = 1; r < 32; r++) begin
      pend_d[r] = pend_q[r];
      if (sb.flush) begin
        pend_d[r] = '0;
      end else if (issue && sb.id_writes_reg && (dst == 5'(r))) begin
        // A new writer replaces whatever was pending; latency 0 clears.
        pend_d[r] = sb.id_latency;
      end else if (pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - 1'b1;
      end
    end
  end

  always_comb begin
    ex_dst_d       = ex_dst_q;
    ex_dst_valid_d = 1'b0;
    if (sb.flush) begin
      ex_dst_d = '0;
    end else if (issue) begin
      ex_dst_d       = dst;
      ex_dst_valid_d = sb.id_writes_reg && (dst != 5'd0);
    end
  end

  // Saturating performance counter; never wraps.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != {CNT_W{1'b1}})) begin
      stall_cycles_d = stall_cycles_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) begin
        pend_q[r] <= '0;
      end
      ex_dst_q       <= '0;
      ex_dst_valid_q <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        pend_q[r] <= pend_d[r];
      end
      ex_dst_q       <= ex_dst_d;
      ex_dst_valid_q <= ex_dst_valid_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign sb.dst_sel      = sb.id_reg_dst;
  assign sb.stall        = stall;
  assign sb.issue        = issue;
  assign sb.ex_dst       = ex_dst_q;
  assign sb.ex_dst_valid = ex_dst_valid_q;
  assign sb.stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_reg_dst_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_reg_dst_scoreboard
//   Directed table of per-cycle vectors for reg_dst_scoreboard, followed by
//   hand-written sequences for reset during a stall and counter saturation.
// ---------------------------------------------------------------------------
module tb_reg_dst_scoreboard;

  localparam int LAT_W = 3;
  localparam int CNT_W = 16;

  typedef struct {
    logic             v;
    logic [4:0]       rs, rt, rd;
    logic             urs, urt, wr, rdst;
    logic [LAT_W-1:0] lat;
    logic             fl;
    logic             e_stall, e_issue;
    logic [4:0]       e_exdst;
    logic             e_exv;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  reg_dst_scoreboard_if #(.LAT_W(LAT_W), .CNT_W(CNT_W)) bus ();

  reg_dst_scoreboard #(.LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sb      (bus.slave)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t t);
    bus.id_valid      = t.v;
    bus.id_rs         = t.rs;
    bus.id_rt         = t.rt;
    bus.id_rd         = t.rd;
    bus.id_uses_rs    = t.urs;
    bus.id_uses_rt    = t.urt;
    bus.id_writes_reg = t.wr;
    bus.id_reg_dst    = t.rdst;
    bus.id_latency    = t.lat;
    bus.flush         = t.fl;
  endtask

  task automatic drive_random();
    bus.id_valid      = 1'($urandom_range(0, 1));
    bus.id_rs         = 5'($urandom_range(0, 31));
    bus.id_rt         = 5'($urandom_range(0, 31));
    bus.id_rd         = 5'($urandom_range(0, 31));
    bus.id_uses_rs    = 1'($urandom_range(0, 1));
    bus.id_uses_rt    = 1'($urandom_range(0, 1));
    bus.id_writes_reg = 1'($urandom_range(0, 1));
    bus.id_reg_dst    = 1'($urandom_range(0, 1));
    bus.id_latency    = LAT_W'($urandom_range(0, 7));
    bus.flush         = 1'($urandom_range(0, 1));
  endtask

  function automatic vec_t mk(
    input logic v, input logic [4:0] rs, rt, rd,
    input logic urs, urt, wr, rdst, input logic [LAT_W-1:0] lat, input logic fl,
    input logic e_stall, e_issue, input logic [4:0] e_exdst, input logic e_exv,
    input logic [CNT_W-1:0] e_cnt);
    vec_t t;
    t.v = v; t.rs = rs; t.rt = rt; t.rd = rd;
    t.urs = urs; t.urt = urt; t.wr = wr; t.rdst = rdst; t.lat = lat; t.fl = fl;
    t.e_stall = e_stall; t.e_issue = e_issue; t.e_exdst = e_exdst;
    t.e_exv = e_exv; t.e_cnt = e_cnt;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    vec_t t;
    int p;
    int nst;
    bit done100;

    //        v  rs  rt  rd urs urt wr rdst lat fl | stall issue exdst exv cnt
    tbl.push_back(mk(1, 31, 17,  0, 1, 1, 0, 1, 0, 0,  0, 1,  0, 0, 0)); // any read after reset
    tbl.push_back(mk(1,  1,  2,  8, 0, 0, 1, 1, 2, 0,  0, 1,  8, 1, 0)); // R-type wr r8 lat2
    tbl.push_back(mk(1,  8,  0,  0, 1, 0, 0, 1, 0, 0,  1, 0,  8, 0, 1)); // reader r8 stalls
    tbl.push_back(mk(1,  8,  0,  0, 1, 0, 0, 1, 0, 0,  1, 0,  8, 0, 2));
    tbl.push_back(mk(1,  8,  0,  0, 1, 0, 0, 1, 0, 0,  0, 1,  0, 0, 2)); // issues at t+L+1
    tbl.push_back(mk(1,  0,  5,  9, 0, 0, 1, 0, 1, 0,  0, 1,  5, 1, 2)); // I-type -> rt=5
    tbl.push_back(mk(1,  9,  0,  0, 1, 0, 0, 0, 0, 0,  0, 1,  0, 0, 2)); // rd=9 not pending
    tbl.push_back(mk(1,  0,  5,  9, 0, 0, 1, 0, 1, 0,  0, 1,  5, 1, 2)); // I-type again
    tbl.push_back(mk(1,  0,  5,  0, 0, 1, 0, 0, 0, 0,  1, 0,  5, 0, 3)); // read rt=5: 1 stall
    tbl.push_back(mk(1,  0,  5,  0, 0, 1, 0, 0, 0, 0,  0, 1,  5, 0, 3));
    tbl.push_back(mk(1,  0,  0,  0, 0, 0, 1, 1, 7, 0,  0, 1,  0, 0, 3)); // write r0 lat7
    tbl.push_back(mk(1,  0,  0,  0, 1, 0, 0, 1, 0, 0,  0, 1,  0, 0, 3)); // read r0: no stall
    tbl.push_back(mk(1,  0,  0,  3, 0, 0, 1, 1, 3, 0,  0, 1,  3, 1, 3)); // wr r3 lat3
    tbl.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 0,  0, 0,  3, 0, 3)); // idle: pend3 -> 2
    tbl.push_back(mk(1,  4,  0,  3, 1, 0, 1, 1, 0, 0,  0, 1,  3, 1, 3)); // overwrite r3 lat0
    tbl.push_back(mk(1,  3,  0,  3, 1, 0, 1, 1, 4, 0,  0, 1,  3, 1, 3)); // self-ref r3, no stall
    tbl.push_back(mk(1,  0,  3,  0, 0, 1, 1, 0, 2, 0,  1, 0,  3, 0, 4)); // hazard on r3
    tbl.push_back(mk(1,  0,  3,  0, 0, 1, 1, 0, 2, 1,  0, 0,  0, 0, 4)); // flush during hazard
    tbl.push_back(mk(1,  0,  3,  0, 0, 1, 1, 0, 2, 0,  0, 1,  3, 1, 4)); // state was cleared
    tbl.push_back(mk(1,  0,  0, 10, 0, 0, 1, 1, 5, 0,  0, 1, 10, 1, 4)); // wr r10 lat5
    tbl.push_back(mk(0,  0,  0,  0, 0, 0, 0, 0, 0, 1,  0, 0,  0, 0, 4)); // flush
    tbl.push_back(mk(1, 10,  0,  0, 1, 0, 0, 1, 0, 0,  0, 1,  0, 0, 4)); // read r10: no stall

    // ---------- reset with random inputs for 2 cycles ----------
    reset_n = 1'b0;
    @(negedge clk); drive_random();
    @(negedge clk); drive_random();
    #1 chk("reset stall", 32'(bus.stall), 32'd0);
    @(posedge clk); #1;
    chk("reset ex_dst", 32'(bus.ex_dst), 32'd0);
    chk("reset ex_dst_valid", 32'(bus.ex_dst_valid), 32'd0);
    chk("reset stall_cycles", 32'(bus.stall_cycles), 32'd0);

    // ---------- table ----------
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset_n = 1'b1;
      t = tbl[i];
      drive(t);
      #1;
      chk($sformatf("row%0d dst_sel", i), 32'(bus.dst_sel), 32'(t.rdst));
      chk($sformatf("row%0d stall", i), 32'(bus.stall), 32'(t.e_stall));
      chk($sformatf("row%0d issue", i), 32'(bus.issue), 32'(t.e_issue));
      if (t.e_exv) exp_q.push_back(t.e_exdst);
      @(posedge clk); #1;
      chk($sformatf("row%0d ex_dst", i), 32'(bus.ex_dst), 32'(t.e_exdst));
      chk($sformatf("row%0d ex_dst_valid", i), 32'(bus.ex_dst_valid), 32'(t.e_exv));
      chk($sformatf("row%0d stall_cycles", i), 32'(bus.stall_cycles), 32'(t.e_cnt));
      if (bus.ex_dst_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("row%0d unexpected write", i), 32'd1, 32'd0);
        end else begin
          chk($sformatf("row%0d write order", i), 32'(bus.ex_dst), 32'(exp_q.pop_front()));
        end
      end
    end
    chk("writes left in queue", 32'(exp_q.size()), 32'd0);

    // ---------- reset in the middle of a stall ----------
    @(negedge clk);
    drive(mk(1, 0, 0, 12, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    drive(mk(1, 12, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    #1 chk("pre-reset stall", 32'(bus.stall), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    chk("mid-stall reset stall_cycles", 32'(bus.stall_cycles), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("post-reset stall", 32'(bus.stall), 32'd0);
    chk("post-reset issue", 32'(bus.issue), 32'd1);

    // ---------- saturation: self-dependent lat7 writer, 7 stalls per 8 cycles ----------
    @(negedge clk);
    drive(mk(1, 1, 0, 1, 1, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0));
    p = 0;
    nst = 0;
    done100 = 1'b0;
    for (int cyc = 0; cyc < 80000 && nst < (1 << CNT_W) + 3; cyc++) begin
      if (cyc != 0) @(negedge clk);
      #1;
      if (cyc < 16) chk($sformatf("sat cyc%0d stall", cyc), 32'(bus.stall), 32'(p != 0));
      if (p != 0) begin
        nst++;
        p--;
      end else begin
        p = 7;
      end
      @(posedge clk); #1;
      if (!done100 && nst == 100) begin
        done100 = 1'b1;
        chk("stall_cycles at 100", 32'(bus.stall_cycles), 32'd100);
      end
    end
    chk("stall_cycles saturated", 32'(bus.stall_cycles), 32'(16'hFFFF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
